// File: rtl/ila_sig_sync_pkg.sv
// ila_sig_sync_pkg
//   Shared constants for the ILA input conditioner: legal synchroniser
//   depth range and default widths, plus a helper used by the top-level
//   elaboration check.
package ila_sig_sync_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int FILT_W_DEF = 4;
    localparam int CNT_W_DEF  = 16;

    function automatic bit stages_ok(input int stages);
        return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
    endfunction

endpackage

// File: rtl/ila_sig_sync_filt.sv
// ila_sig_filt
//   One-bit glitch filter with edge-pulse generation. The filtered level
//   follows the synchronised input only after the input has differed from
//   it for L consecutive enabled cycles.
// Ports
//   clk_i, arst_i : clock, async active-high reset
//   en_i          : enable; when low, counter and level hold, pulses clear
//   lm1_i         : L-1 (already clamped so that a length of 0 acts as 1)
//   s_i           : synchronised input bit
//   lvl_o         : filtered level
//   rise_o/fall_o : registered 1-cycle pulses on level 0->1 / 1->0
module ila_sig_filt
    import ila_sig_sync_pkg::*;
#(
    parameter int FILT_W  = FILT_W_DEF,
    parameter bit RST_VAL = 1'b0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              en_i,
    input  logic [FILT_W-1:0] lm1_i,
    input  logic              s_i,
    output logic              lvl_o,
    output logic              rise_o,
    output logic              fall_o
);

    logic [FILT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q  <= '0;
            lvl_o  <= RST_VAL;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            // Pulses are strictly one cycle: cleared unless set below.
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (en_i) begin
                if (s_i == lvl_o) begin
                    cnt_q <= '0;
                end else if (cnt_q >= lm1_i) begin
                    // ">=" so a lowered length commits at once if the
                    // difference persists; the counter can never wrap.
                    lvl_o  <= s_i;
                    cnt_q  <= '0;
                    rise_o <= s_i;
                    fall_o <= ~s_i;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ila_sig_sync.sv
// ila_sig_sync
//   Multi-channel conditioner for asynchronous ILA probe/trigger inputs:
//   STAGES-deep synchroniser, per-channel glitch filter, edge pulses and a
//   saturating count of cycles in which any channel changed.
// Ports
//   clk_i, arst_i : clock, async active-high reset
//   en_i          : filter/edge enable (the sync chain always runs)
//   filt_len_i    : required stability length L; 0 is treated as 1
//   cnt_clr_i     : synchronous clear of chg_cnt_o (wins over increment)
//   data_i        : raw asynchronous inputs
//   data_o        : synchronised, filtered levels
//   rise_o/fall_o : 1-cycle pulses aligned with data_o transitions
//   chg_o         : any pulse this cycle
//   chg_cnt_o     : saturating count of chg_o cycles
module ila_sig_sync
    import ila_sig_sync_pkg::*;
#(
    parameter int             W       = 8,
    parameter int             STAGES  = 2,
    parameter int             FILT_W  = FILT_W_DEF,
    parameter int             CNT_W   = CNT_W_DEF,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic              cnt_clr_i,
    input  logic [W-1:0]      data_i,
    output logic [W-1:0]      data_o,
    output logic [W-1:0]      rise_o,
    output logic [W-1:0]      fall_o,
    output logic              chg_o,
    output logic [CNT_W-1:0]  chg_cnt_o
);

    if (!stages_ok(STAGES)) begin : g_bad_stages
        $error("ila_sig_sync: STAGES must be within 2..4");
    end

    // Plain flop chain; nothing may sit between stages.
    logic [STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]             s;
    logic [FILT_W-1:0]        lm1;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q[0] <= data_i;
            for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[STAGES-1];

    // Length 0 behaves as 1, i.e. commit threshold L-1 = 0.
    assign lm1 = (filt_len_i == '0) ? '0 : filt_len_i - 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_ch
        ila_sig_filt #(
            .FILT_W  (FILT_W),
            .RST_VAL (RST_VAL[i])
        ) u_filt (
            .clk_i  (clk_i),
            .arst_i (arst_i),
            .en_i   (en_i),
            .lm1_i  (lm1),
            .s_i    (s[i]),
            .lvl_o  (data_o[i]),
            .rise_o (rise_o[i]),
            .fall_o (fall_o[i])
        );
    end

    assign chg_o = |(rise_o | fall_o);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            chg_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            chg_cnt_o <= '0;
        end else if (chg_o && (chg_cnt_o != {CNT_W{1'b1}})) begin
            chg_cnt_o <= chg_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_ila_sig_sync.sv
module tb_ila_sig_sync;

    logic       clk = 1'b0;
    logic       arst_i;
    logic       en_i;
    logic [3:0] filt_len_i;
    logic       cnt_clr_i;
    logic [7:0] data_i;

    logic [7:0]  o_dat [2];
    logic [7:0]  o_rise[2];
    logic [7:0]  o_fall[2];
    logic        o_chg [2];
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: deeper sync and a narrow counter.
    ila_sig_sync #(.W(8), .STAGES(2), .FILT_W(4), .CNT_W(16)) dut_a (
        .clk_i(clk), .arst_i(arst_i), .en_i(en_i), .filt_len_i(filt_len_i),
        .cnt_clr_i(cnt_clr_i), .data_i(data_i), .data_o(o_dat[0]),
        .rise_o(o_rise[0]), .fall_o(o_fall[0]), .chg_o(o_chg[0]), .chg_cnt_o(cnt_a));

    ila_sig_sync #(.W(8), .STAGES(3), .FILT_W(4), .CNT_W(4)) dut_b (
        .clk_i(clk), .arst_i(arst_i), .en_i(en_i), .filt_len_i(filt_len_i),
        .cnt_clr_i(cnt_clr_i), .data_i(data_i), .data_o(o_dat[1]),
        .rise_o(o_rise[1]), .fall_o(o_fall[1]), .chg_o(o_chg[1]), .chg_cnt_o(cnt_b));

    // Reference model: a delay line of raw samples, and per channel the
    // number of consecutive enabled cycles the delayed sample has disagreed
    // with the published level. Level commits once that run reaches L.
    int         STG [2] = '{2, 3};
    int         CMAX[2] = '{65535, 15};
    logic [7:0] m_hist[2][4];
    logic [7:0] m_lvl [2];
    logic [7:0] m_rise[2];
    logic [7:0] m_fall[2];
    int         m_run [2][8];
    int         m_cnt [2];

    int nchk = 0;
    int nerr = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) m_hist[k][j] = 8'h00;
            m_lvl[k] = 8'h00; m_rise[k] = 8'h00; m_fall[k] = 8'h00; m_cnt[k] = 0;
            for (int c = 0; c < 8; c++) m_run[k][c] = 0;
        end
    endtask

    task automatic model_edge();
        int L;
        L = (filt_len_i == 0) ? 1 : int'(filt_len_i);
        for (int k = 0; k < 2; k++) begin
            logic [7:0] sv;
            logic       any_chg;
            any_chg = |(m_rise[k] | m_fall[k]);
            sv = m_hist[k][STG[k]-1];
            m_rise[k] = 8'h00;
            m_fall[k] = 8'h00;
            if (en_i) begin
                for (int c = 0; c < 8; c++) begin
                    if (sv[c] == m_lvl[k][c]) m_run[k][c] = 0;
                    else begin
                        m_run[k][c] = m_run[k][c] + 1;
                        if (m_run[k][c] >= L) begin
                            m_lvl[k][c] = sv[c];
                            if (sv[c]) m_rise[k][c] = 1'b1; else m_fall[k][c] = 1'b1;
                            m_run[k][c] = 0;
                        end
                    end
                end
            end
            if (cnt_clr_i) m_cnt[k] = 0;
            else if (any_chg && m_cnt[k] < CMAX[k]) m_cnt[k] = m_cnt[k] + 1;
            for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
            m_hist[k][0] = data_i;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string ph);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s d%0d data_o", ph, k), {24'h0, o_dat[k]},  {24'h0, m_lvl[k]});
            chk($sformatf("%s d%0d rise_o", ph, k), {24'h0, o_rise[k]}, {24'h0, m_rise[k]});
            chk($sformatf("%s d%0d fall_o", ph, k), {24'h0, o_fall[k]}, {24'h0, m_fall[k]});
            chk($sformatf("%s d%0d chg_o", ph, k),  {31'h0, o_chg[k]},
                {31'h0, |(m_rise[k] | m_fall[k])});
        end
        chk({ph, " d0 chg_cnt_o"}, {16'h0, cnt_a}, m_cnt[0]);
        chk({ph, " d1 chg_cnt_o"}, {28'h0, cnt_b}, m_cnt[1]);
    endtask

    task automatic step(input string ph, input logic [7:0] d, input logic e,
                        input logic [3:0] l, input logic c);
        data_i = d; en_i = e; filt_len_i = l; cnt_clr_i = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(ph);
    endtask

    // Asynchronous pulse placed between clock edges.
    task automatic rst_pulse(input string ph);
        #2;
        arst_i = 1'b1;
        #1;
        model_reset();
        compare_all(ph);
        #1;
        arst_i = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [3:0] len;
        arst_i = 1'b1; en_i = 1'b1; filt_len_i = 4'd3; cnt_clr_i = 1'b0; data_i = 8'hFF;
        model_reset();

        // Held in reset with all inputs high: everything reads zero.
        repeat (2) @(posedge clk);
        #1;
        compare_all("in_reset");
        arst_i = 1'b0;
        for (int n = 0; n < 8; n++) step("rst_release", 8'hFF, 1'b1, 4'd3, 1'b0);

        // Short pulse rejected, longer one accepted (L=4).
        step("glitch", 8'hFE, 1'b1, 4'd4, 1'b0);
        step("glitch", 8'hFE, 1'b1, 4'd4, 1'b0);
        for (int n = 0; n < 8; n++) step("glitch", 8'hFF, 1'b1, 4'd4, 1'b0);
        for (int n = 0; n < 6; n++) step("glitch", 8'hFE, 1'b1, 4'd4, 1'b0);
        for (int n = 0; n < 10; n++) step("glitch", 8'hFF, 1'b1, 4'd4, 1'b0);

        // Length 0 and 1 both give minimum latency.
        for (int n = 0; n < 5; n++) step("len0", 8'h0F, 1'b1, 4'd0, 1'b0);
        for (int n = 0; n < 5; n++) step("len1", 8'hF0, 1'b1, 4'd1, 1'b0);

        // Disabled while toggling, then enabled with a stable difference.
        for (int n = 0; n < 5; n++) step("en_off", (n % 2) ? 8'hF0 : 8'h5A, 1'b0, 4'd2, 1'b0);
        for (int n = 0; n < 4; n++) step("en_off", 8'h3C, 1'b0, 4'd2, 1'b0);
        for (int n = 0; n < 8; n++) step("en_on", 8'h3C, 1'b1, 4'd2, 1'b0);

        // Many change events: narrow counter saturates.
        d = 8'h00;
        for (int n = 0; n < 50; n++) begin
            if (n % 2 == 0) d = ~d;
            step("sat", d, 1'b1, 4'd1, 1'b0);
        end
        // Clear while changes keep arriving: clear must win.
        for (int n = 0; n < 12; n++) begin
            d = ~d;
            step("clr", d, 1'b1, 4'd1, n[0]);
        end

        // Reset in the middle of a pending update (L=4).
        for (int n = 0; n < 6; n++) step("pre_arst", 8'h00, 1'b1, 4'd4, 1'b0);
        for (int n = 0; n < 4; n++) step("pre_arst", 8'h81, 1'b1, 4'd4, 1'b0);
        rst_pulse("arst_mid");
        for (int n = 0; n < 10; n++) step("post_arst", 8'h81, 1'b1, 4'd4, 1'b0);

        // Randomised traffic, including runtime length changes.
        d = 8'h00;
        len = 4'd2;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) d = d ^ 8'($urandom);
            if (n % 37 == 0) len = 4'($urandom_range(0, 5));
            step("rand", d, $urandom_range(0, 7) != 0, len, $urandom_range(0, 29) == 0);
            if (n == 200) rst_pulse("rand_arst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
